core_sequencer: RTL
===================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL provide parameter PC_RESET, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of wait cycles for a memory ack (used only with SEQ_TIMEOUT_EN).
REQ-003 The ports SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address, equal to pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  instruction register (IR), fed to the decoder.
- dec_rf_we, dec_mem_we, dec_is_load, dec_branch  in  1 each  decoder flags for IR.
- alu_zero  in  1  ALU result is zero.
- br_offset  in  32  signed branch offset.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write qualifier.
- dmem_ack  in  1  data access complete.
- rf_we  out  1  register-file write strobe.
- pc  out  32  program counter.
- state  out  3  current FSM state.
- retire  out  1  one-cycle pulse per completed instruction.
- fault  out  1  sticky timeout flag.
REQ-004 Reset SHALL use one clock, clk; rst_n is asynchronous and active-low.

Function
REQ-005 The FSM SHALL use the encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; the other codes SHALL go to FETCH on the next edge.
REQ-006 FETCH behaviour:
- imem_req=1 and imem_addr=pc, both held stable until imem_ack.
- On imem_ack, IR<=imem_rdata and the FSM goes to DECODE.
REQ-007 DECODE SHALL last exactly one cycle, then go to EXEC; decoder flags are not sampled in DECODE.
REQ-008 EXEC SHALL last one cycle, then go to MEM if dec_mem_we or dec_is_load is 1, and to WB otherwise.
REQ-009 MEM behaviour:
- dmem_req=1 and dmem_we=dec_mem_we, held until dmem_ack.
- On dmem_ack, go to WB.
REQ-010 WB SHALL last exactly one cycle with these outputs:
- rf_we=dec_rf_we.
- retire=1.
- pc <= pc+br_offset if dec_branch=1 and alu_zero=0, else pc <= pc+4.
- Next state is FETCH.
REQ-011 All pc arithmetic SHALL be modulo 2^32, e.g. 32'hFFFF_FFFC+4 = 32'h0.
REQ-012 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-013 rf_we, retire, imem_req, dmem_req and dmem_we SHALL be 0 in every state not named for them above.
REQ-014 Latency SHALL be 4 cycles per non-memory instruction with a same-cycle ack, and 5 cycles minimum for load/store; each ack wait cycle adds one cycle.
REQ-015 IR and pc SHALL change only on the edges defined in REQ-006 and REQ-010.

Reset
REQ-016 While rst_n=0, the outputs SHALL be:
- state=FETCH, pc=PC_RESET, IR=0.
- fault=0, timeout counter=0.
- rf_we, retire, dmem_req, dmem_we all 0.
REQ-017 Reset asserted mid-operation SHALL abandon any outstanding request immediately, with no write or retire.
REQ-018 After rst_n deasserts, the first rising edge SHALL begin the FETCH of PC_RESET, with imem_req=1.

Configuration
REQ-019 With SEQ_TIMEOUT_EN defined:
- A counter SHALL increment on each FETCH or MEM cycle without an ack, and clear on ack or state change.
- When the counter reaches TIMEOUT_CYCLES, the FSM SHALL enter HALT with fault=1.
- In HALT, all requests and strobes are 0, and only reset exits HALT.
REQ-020 Without SEQ_TIMEOUT_EN:
- No counter SHALL exist, fault SHALL be tied to 0, and HALT SHALL be unreachable.
- The FSM SHALL wait indefinitely for ack.

Verification
REQ-021 The bench SHALL cover these scenarios:
- ADDI at pc=0, imem_ack same cycle, dec_rf_we=1 -> rf_we high 4th cycle, retire once, pc=4.
- SW with dmem_ack delayed 3 cycles -> dmem_req=dmem_we=1 for 4 cycles, rf_we=0, retire in cycle 8, pc=4.
- BNE with alu_zero=0, br_offset=32'hFFFF_FFF8, pc=0x10 -> pc=0x08; with alu_zero=1 -> pc=0x14.
- pc=32'hFFFF_FFFC non-branch -> pc wraps to 0; stray dmem_ack during FETCH -> no effect.
- rst_n low during MEM with dmem_req=1 -> dmem_req=0 immediately, pc=PC_RESET, no retire.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_ack never -> state=HALT, fault=1 after 16 wait cycles; without macro -> still FETCH after 100 cycles, fault=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Optional ack watchdog enabled by defining SEQ_TIMEOUT_EN (halts with sticky fault).
module core_sequencer #(
  parameter logic [31:0] PC_RESET       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_rf_we,
  input  logic        dec_mem_we,
  input  logic        dec_is_load,
  input  logic        dec_branch,
  input  logic        alu_zero,
  input  logic [31:0] br_offset,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        retire,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic        wait_cycle;
  logic        timeout_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic          fault_reg, fault_next;

  // Counter only runs while stalled on an ack; any progress clears it.
  assign timeout_hit = wait_cycle && (tmo_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_next = '0;
    fault_next   = fault_reg;
    if (wait_cycle) begin
      tmo_cnt_next = timeout_hit ? CW'(TIMEOUT_CYCLES) : tmo_cnt_reg + 1'b1;
    end
    if (timeout_hit) begin
      fault_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
      fault_reg   <= 1'b0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
      fault_reg   <= fault_next;
    end
  end

  assign fault = fault_reg;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
  wire unused_cfg = ^{TIMEOUT_CYCLES, wait_cycle, timeout_hit};
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    wait_cycle = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_next    = imem_rdata;
          state_next = S_DECODE;
        end else begin
          wait_cycle = 1'b1;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (dec_mem_we || dec_is_load) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_we;
        if (dmem_ack) begin
          state_next = S_WB;
        end else begin
          wait_cycle = 1'b1;
        end
      end
      S_WB: begin
        rf_we      = dec_rf_we;
        retire     = 1'b1;
        pc_next    = (dec_branch && !alu_zero) ? pc_reg + br_offset : pc_reg + 32'd4;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
    if (timeout_hit) begin
      state_next = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= PC_RESET;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  assign state     = state_reg;
  assign pc        = pc_reg;
  assign imem_addr = pc_reg;
  assign instr     = ir_reg;

endmodule
